serial_comp: RTL

SERIAL_COMP -- requirements
Module: serial_comp

---
 rtl/serial_comp.sv | 111 +++++++++++
 1 files changed

// File: rtl/serial_comp.sv
// Serial magnitude comparator: operands arrive as 2-bit digits, most significant first.
// The first differing digit pair decides the outcome; the result is registered and held.
module serial_comp #(
    parameter int unsigned NDIG = 4,
    localparam int unsigned CntW = $clog2(NDIG + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    input  logic [1:0]      a_dig,
    input  logic [1:0]      b_dig,
    output logic            busy,
    output logic            done,
    output logic            greater,
    output logic            lesser,
    output logic            equal,
    output logic [CntW-1:0] dig_cnt
);

    typedef enum logic [1:0] {StIdle, StCompare, StDone} state_e;

    state_e          state_q;
    logic            busy_q, done_q;
    logic            greater_q, lesser_q, equal_q;
    logic [CntW-1:0] cnt_q;
    logic            decided_q, gt_q, lt_q;

    logic            gt_d, lt_d, decided_d, last_dig;

    // Outcome including the digit pair on the inputs this cycle.
    always_comb begin
        gt_d      = gt_q;
        lt_d      = lt_q;
        decided_d = decided_q | (a_dig != b_dig);
        if (!decided_q && (a_dig != b_dig)) begin
            gt_d = (a_dig > b_dig);
            lt_d = (a_dig < b_dig);
        end
        last_dig = (cnt_q == CntW'(NDIG - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            greater_q <= 1'b0;
            lesser_q  <= 1'b0;
            equal_q   <= 1'b0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q   <= StCompare;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        decided_q <= 1'b0;
                        gt_q      <= 1'b0;
                        lt_q      <= 1'b0;
                        greater_q <= 1'b0;
                        lesser_q  <= 1'b0;
                        equal_q   <= 1'b0;
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                StCompare: begin
                    if (start) begin
                        // Restart in place; digits on the bus this cycle are dropped.
                        cnt_q     <= '0;
                        decided_q <= 1'b0;
                        gt_q      <= 1'b0;
                        lt_q      <= 1'b0;
                    end else if (in_valid) begin
                        cnt_q     <= cnt_q + CntW'(1);
                        decided_q <= decided_d;
                        gt_q      <= gt_d;
                        lt_q      <= lt_d;
                        if (last_dig) begin
                            state_q   <= StDone;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            greater_q <= gt_d;
                            lesser_q  <= lt_d;
                            equal_q   <= ~decided_d;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign greater = greater_q;
    assign lesser  = lesser_q;
    assign equal   = equal_q;
    assign dig_cnt = cnt_q;

endmodule
